// File: rtl/nibble_serial_adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    // Byte and nibble counters both span 0..NIBBLES-1 (2*BPO == NIBBLES).
    function automatic int cnt_w(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_seq_nibble_shreg.sv
// Register with byte write at an index and shift-right-by-one-nibble.
module nibble_shreg
    import nibble_serial_adder_seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [IDX_W-1:0]    load_idx,
    input  logic [BYTE_W-1:0]   load_byte,
    input  logic                shift_en,
    input  logic [NIBBLE_W-1:0] shift_in,
    output logic [W-1:0]        q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {shift_in, q[W-1:NIBBLE_W]};
        end else if (load_en) begin
            for (int k = 0; k < W / BYTE_W; k++) begin
                if (load_idx == IDX_W'(k))
                    q[k*BYTE_W +: BYTE_W] <= load_byte;
            end
        end
    end

endmodule

// File: rtl/nibble_serial_adder_seq.sv
// Time-multiplexes an external 4-bit adder into a 4*NIBBLES-bit adder,
// loading operands bytewise and streaming one nibble per cycle, LS first.
module nibble_serial_adder_seq
    import nibble_serial_adder_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W-1:0]             in_data,
    input  logic                          cin_in,
    output logic [NIBBLE_W-1:0]           add_a,
    output logic [NIBBLE_W-1:0]           add_b,
    output logic                          add_cin,
    input  logic [NIBBLE_W-1:0]           add_sum,
    input  logic                          add_carry,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_sum,
    output logic                          out_carry,
    output logic                          busy
);

    localparam int W   = NIBBLE_W * NIBBLES;
    localparam int BPO = NIBBLES / 2;
    localparam int CW  = cnt_w(NIBBLES);

    state_t        state, state_nx;
    logic [CW-1:0] byte_cnt, nib_cnt;
    logic          carry_q, out_carry_q;
    logic [W-1:0]  a_q, b_q, res_q;
    logic          accept, run, last_byte, last_nib, in_b;
    logic          unused_hi;

    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_LOAD);
    assign run       = (state == ST_RUN);
    assign accept    = in_valid & in_ready;
    assign last_byte = (byte_cnt == CW'(NIBBLES - 1));
    assign last_nib  = (nib_cnt == CW'(NIBBLES - 1));
    assign in_b      = (byte_cnt >= CW'(BPO));

    assign add_a   = run ? a_q[NIBBLE_W-1:0] : '0;
    assign add_b   = run ? b_q[NIBBLE_W-1:0] : '0;
    assign add_cin = run ? carry_q : 1'b0;

    // Only the low nibble of each operand feeds the adder; the rest shifts down.
    assign unused_hi = ^{a_q[W-1:NIBBLE_W], b_q[W-1:NIBBLE_W]};

    assign out_sum   = res_q;
    assign out_carry = out_carry_q;

    nibble_shreg #(.W(W), .IDX_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n),
        .load_en(accept & ~in_b), .load_idx(byte_cnt), .load_byte(in_data),
        .shift_en(run), .shift_in('0), .q(a_q)
    );

    nibble_shreg #(.W(W), .IDX_W(CW)) u_b (
        .clk(clk), .rst_n(rst_n),
        .load_en(accept & in_b), .load_idx(byte_cnt - CW'(BPO)), .load_byte(in_data),
        .shift_en(run), .shift_in('0), .q(b_q)
    );

    // Result fills from the top so the LS nibble lands at bit 0 after NIBBLES shifts.
    nibble_shreg #(.W(W), .IDX_W(CW)) u_res (
        .clk(clk), .rst_n(rst_n),
        .load_en(1'b0), .load_idx('0), .load_byte('0),
        .shift_en(run), .shift_in(add_sum), .q(res_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_LOAD: if (accept && last_byte) state_nx = ST_RUN;
            ST_RUN:  if (last_nib)            state_nx = ST_DONE;
            ST_DONE: if (out_ready)           state_nx = ST_LOAD;
            default:                          state_nx = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            nib_cnt     <= '0;
            carry_q     <= 1'b0;
            out_carry_q <= 1'b0;
        end else begin
            if (accept)
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            else if (out_valid && out_ready)
                byte_cnt <= '0;

            if (run)
                nib_cnt <= last_nib ? '0 : nib_cnt + 1'b1;

            if (accept && byte_cnt == '0)
                carry_q <= cin_in;
            else if (run)
                carry_q <= add_carry;

            // Separate output copy so loading the next cin doesn't disturb out_carry.
            if (run && last_nib)
                out_carry_q <= add_carry;
        end
    end

endmodule

// File: doc/nibble_serial_adder_seq.md
# nibble_serial_adder_seq

Sequencer that widens the 4-bit combinational nibble adder to a multi-nibble adder by time-multiplexing it. It loads two operands bytewise over a valid/ready input, then drives the adder's `a`/`b`/`cin` one nibble per cycle, least-significant nibble first. It chains the adder's `carry` back into `cin` and assembles the returned sums into a wide result with a valid/ready output. It sits directly upstream of the adder, feeds it, and consumes its `sum`/`carry` in the same cycle.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width is 4*NIBBLES bits. Must be even and ≥2. BPO = NIBBLES/2 bytes per operand.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand byte valid.
- `in_ready`  out  1  block accepts a byte. High only in LOAD.
- `in_data`  in  8  operand byte.
- `cin_in`  in  1  carry-in. Sampled with the first accepted byte only.
- `add_a`  out  4  adder operand a.
- `add_b`  out  4  adder operand b.
- `add_cin`  out  1  adder carry-in.
- `add_sum`  in  4  adder sum, combinational from `add_*`.
- `add_carry`  in  1  adder carry-out.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  4*NIBBLES  result, mod 2^(4*NIBBLES).
- `out_carry`  out  1  final carry-out.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States: LOAD, RUN, DONE.
- LOAD:
  - `in_ready`=1. Each accepted byte (`in_valid & in_ready`) increments the byte counter 0..2*BPO-1.
  - Bytes 0..BPO-1 fill A, LS byte first. Bytes BPO..2*BPO-1 fill B, LS byte first.
  - Byte 0 also latches `cin_in` into the carry register.
  - Acceptance of the last byte moves the block to RUN.
  - Gaps in `in_valid` are allowed.
- RUN, exactly NIBBLES cycles with nibble counter i = 0..NIBBLES-1:
  - `add_a`=A[3:0], `add_b`=B[3:0], `add_cin`=carry register.
  - At each edge: the result register shifts right by 4 with `add_sum` entering the top nibble; A and B shift right by 4; the carry register takes `add_carry`.
  - After i=NIBBLES-1, go to DONE.
- DONE:
  - `out_valid`=1. `out_sum` = result register, `out_carry` = carry register. Both held stable until handshake.
  - `out_valid & out_ready` moves the block to LOAD and clears the byte counter. `out_sum`/`out_carry` keep their values until the next RUN overwrites them.
- Outside RUN, `add_a`, `add_b` and `add_cin` are forced to 0.
- `in_valid` while not in LOAD is ignored; no byte is consumed.
- `out_ready` may be high before `out_valid`. The handshake then completes in the first DONE cycle.
- Arithmetic: {`out_carry`,`out_sum`} = A + B + cin, exact, width 4*NIBBLES+1.

## Timing
- Reset (asynchronous assert, synchronous release): state LOAD, `in_ready`=1, `out_valid`=0, `busy`=0, `out_sum`=0, `out_carry`=0, `add_*`=0, all counters and operand/carry registers 0.
- Reset mid-operation: partial operands and results are discarded, the block returns to LOAD, and no `out_valid` pulse occurs.
- Latency: last byte accepted at edge E → RUN cycles E..E+NIBBLES-1 → `out_valid` rises after edge E+NIBBLES.
- Minimum period with no stalls is 2*BPO + NIBBLES + 1 cycles (9 for the default).
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- The adder is a combinational path within the RUN cycle: `add_*` → `add_sum`/`add_carry` → registers.

## Structure
- Shared package:
  - State typedef (LOAD/RUN/DONE).
  - `NIBBLE_W`=4 and `BYTE_W`=8 constants.
  - Function computing counter widths from NIBBLES.
- One natural sub-module: `nibble_shreg`, a width-parameterised register with byte-load at index and shift-right-by-4. Instantiated for A, B and the result.
- The 4-bit adder is instantiated by the parent, not inside this block. Benches instantiate both.

## Test plan
- A=0x1234, B=0x4321, cin=0, bytes 34,12,21,43 → `out_sum`=0x5555, `out_carry`=0. `out_valid` appears 4 cycles after the last byte.
- A=0xFFFF, B=0x0001, cin=0 → `out_sum`=0x0000, `out_carry`=1. Full ripple across all nibbles.
- A=0xFFFF, B=0x0000, cin=1 → `out_sum`=0x0000, `out_carry`=1. `cin_in` toggled after byte 0 has no effect.
- Backpressure case, A=0x00FF, B=0x0F01:
  - `in_valid` gaps of 3 cycles between bytes.
  - `out_ready`=0 for 5 cycles → `out_sum`=0x1000 held stable, `in_ready`=0, and extra `in_valid` bytes are not consumed.
- Reset asserted on RUN cycle 2 → all outputs at reset values immediately. A new load of 0x0001+0x0001 → `out_sum`=0x0002.
- Back-to-back ops with `out_ready` tied 1 → second result `out_valid` exactly 9 cycles after the first.
